// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: steps each instruction through FETCH, DECODE,
// EXECUTE, MEMORY and WRITEBACK. It drives the datapath write enables and the
// instruction/data memory req/ack handshakes. It also runs an ack-timeout
// watchdog that traps the core, and counts retired instructions.
module multicycle_controller #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   haltReq,
  input  logic                   isLegal,
  input  logic                   isLoad,
  input  logic                   isStore,
  input  logic                   isBranch,
  input  logic                   isJump,
  input  logic                   regWrEnable,
  output logic                   imemReq,
  input  logic                   imemAck,
  output logic                   dmemReq,
  output logic                   dmemWe,
  input  logic                   dmemAck,
  output logic                   irWrEnable,
  output logic                   pcWrEnable,
  output logic                   rfWrEnable,
  output logic [2:0]             state,
  output logic                   trap,
  output logic [1:0]             trapCause,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_UNUSED    = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  // Wide enough to count up to TIMEOUT without wrapping before the trap fires.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1) + 1;

  state_t           cur_state;
  state_t           next_state;
  logic [1:0]       next_cause;
  logic [CNT_W-1:0] wait_cnt;
  logic [63:0]      wait_ext;
  logic             timeout_hit;
  state_t           retire_state;

  // Branch and jump flags do not change the sequencing: a branch is simply
  // the "no memory, no rd write" case, and a jump writes rd like an ALU op.
  logic unused_flags;
  assign unused_flags = ^{isBranch, isJump};

  // This cycle would be the TIMEOUT-th wait without an ack.
  assign wait_ext    = 64'(wait_cnt);
  assign timeout_hit = (TIMEOUT != 0) && ((wait_ext + 64'd1) >= 64'(TIMEOUT));

  // An instruction boundary goes idle while halt is requested.
  assign retire_state = haltReq ? S_IDLE : S_FETCH;

  assign state = cur_state;
  assign trap  = (cur_state == S_TRAP);

  // State register; reset drops straight to IDLE, aborting any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= S_IDLE;
    else     cur_state <= next_state;
  end

  // Next-state logic plus Moore/Mealy enables and memory requests.
  always_comb begin
    next_state = cur_state;
    next_cause = trapCause;
    imemReq    = 1'b0;
    irWrEnable = 1'b0;
    dmemReq    = 1'b0;
    dmemWe     = 1'b0;
    pcWrEnable = 1'b0;
    rfWrEnable = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (!haltReq) next_state = S_FETCH;
      end
      S_FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          irWrEnable = 1'b1;
          next_state = S_DECODE;
        end else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = 2'd1;
        end
      end
      S_DECODE: begin
        if (!isLegal) begin
          next_state = S_TRAP;
          next_cause = 2'd3;
        end else begin
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (isLoad || isStore) begin
          next_state = S_MEMORY;
        end else if (regWrEnable) begin
          next_state = S_WRITEBACK;
        end else begin
          pcWrEnable = 1'b1;
          next_state = retire_state;
        end
      end
      S_MEMORY: begin
        dmemReq = 1'b1;
        dmemWe  = isStore && !isLoad;
        if (dmemAck) begin
          if (isLoad) begin
            next_state = S_WRITEBACK;
          end else begin
            pcWrEnable = 1'b1;
            next_state = retire_state;
          end
        end else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = 2'd2;
        end
      end
      S_WRITEBACK: begin
        rfWrEnable = 1'b1;
        pcWrEnable = 1'b1;
        next_state = retire_state;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Trap cause is written only on the transition into TRAP and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trapCause <= 2'd0;
    else     trapCause <= next_cause;
  end

  // Retired-instruction counter; every PC write marks a retirement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             retiredCount <= '0;
    else if (pcWrEnable) retiredCount <= retiredCount + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // Watchdog wait counter: cleared on any state change, counts ack-less
  // cycles while a memory request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               wait_cnt <= '0;
    else if (next_state != cur_state)                      wait_cnt <= '0;
    else if (cur_state == S_FETCH || cur_state == S_MEMORY) wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences a multicycle RV32I core: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Consumes per-instruction class flags from the decode unit, which decodes the instruction register combinationally.
- Drives the datapath enables and the req/ack handshakes to instruction and data memory.
- Provides a halt request, an ack-timeout watchdog with trap reporting, and a retired-instruction counter.

Parameters:
TIMEOUT, 255, max cycles a memory req may wait for ack before trapping; 0 disables the watchdog.
COUNT_WIDTH, 32, width of retiredCount.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
haltReq  input  1  when high at an instruction boundary, stay in IDLE.
isLegal  input  1  decoded opcode is legal; sampled in DECODE.
isLoad  input  1  decoded load.
isStore  input  1  decoded store.
isBranch  input  1  decoded branch.
isJump  input  1  decoded JAL/JALR.
regWrEnable  input  1  decoded instruction writes rd.
imemReq  output  1  instruction fetch request.
imemAck  input  1  instruction fetch complete, data valid this cycle.
dmemReq  output  1  data memory request.
dmemWe  output  1  data request is a write.
dmemAck  input  1  data access complete, load data valid this cycle.
irWrEnable  output  1  latch instruction register.
pcWrEnable  output  1  update PC (next PC selected by datapath).
rfWrEnable  output  1  register file write.
state  output  3  current state encoding.
trap  output  1  core is in TRAP.
trapCause  output  2  0 none, 1 imem timeout, 2 dmem timeout, 3 illegal instruction.
retiredCount  output  COUNT_WIDTH  instructions retired since reset.

Behaviour:
- Encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=7. Code 6 is unused; if reached, go to IDLE.
- Reset (async, immediate):
  - state=IDLE; trapCause=0; retiredCount=0; wait counter=0.
  - All enables and reqs are derived from state, so all are 0 in IDLE.
- IDLE: if !haltReq, go to FETCH next cycle.
- FETCH:
  - imemReq=1 for the whole state.
  - On imemAck: irWrEnable=1 (same cycle, Mealy), next DECODE.
  - An ack in the first FETCH cycle is accepted (zero-wait).
- DECODE:
  - If !isLegal: trapCause=3, next TRAP.
  - Otherwise next EXECUTE. No enables asserted.
- EXECUTE:
  - isLoad or isStore: next MEMORY. isLoad has priority if both are asserted.
  - Else if regWrEnable (ALU op, LUI/AUIPC, jump): next WRITEBACK.
  - Else (branch): pcWrEnable=1 this cycle and retire.
- MEMORY:
  - dmemReq=1; dmemWe=isStore && !isLoad.
  - On dmemAck: load goes to WRITEBACK; store asserts pcWrEnable=1 and retires.
- WRITEBACK: rfWrEnable=1, pcWrEnable=1, retire.
- Retire:
  - retiredCount increments by 1 in every cycle with pcWrEnable=1, wrapping modulo 2^COUNT_WIDTH.
  - Next state is IDLE if haltReq, else FETCH. haltReq never aborts an instruction in flight.
- Watchdog:
  - The wait counter clears on entering FETCH or MEMORY and increments each cycle in those states without ack.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no ack, next state is TRAP with cause 1 (FETCH) or 2 (MEMORY).
  - An ack arriving in that same cycle wins; no trap.
- Acks outside the matching req state are ignored and have no effect.
- TRAP: trap=1; all enables and reqs are 0; state is held until rst. trapCause holds its value until reset.
- Latency with zero-wait memory:
  - branch 3 cycles.
  - ALU/jump 4 cycles.
  - store 4 cycles.
  - load 5 cycles.
  - Each memory wait cycle adds 1.
- Reset mid-instruction aborts immediately: no pc/rf write and no count increment occurs after rst asserts.

Test Plan:
- ALU op (regWrEnable=1), imemAck in first FETCH cycle -> states 1,2,3,5,1.
  - rfWrEnable and pcWrEnable high only in cycle 4.
  - retiredCount goes 0->1.
- Load, dmemAck delayed 2 cycles -> MEMORY lasts 3 cycles with dmemReq=1, dmemWe=0.
  - WRITEBACK follows; total 7 cycles; retiredCount+1.
- Store then branch back-to-back, zero wait -> store is 4 cycles with dmemWe=1 and pcWrEnable in MEMORY.
  - Branch is 3 cycles with pcWrEnable in EXECUTE; rfWrEnable never asserted.
  - retiredCount=2.
- TIMEOUT=4, imemAck never arrives -> TRAP after 4 FETCH waits (trap=1, trapCause=1, state=7).
  - Later imemAck and haltReq are ignored until rst.
- isLegal=0 in DECODE -> TRAP with trapCause=3; irWrEnable pulsed once; no pcWrEnable.
- haltReq=1 during EXECUTE of an ALU op -> WRITEBACK completes, then IDLE.
  - Deasserting haltReq gives FETCH next cycle.
  - rst pulsed during MEMORY -> IDLE, dmemReq=0 and retiredCount=0 immediately.
